// File: rtl/ddr_cmd_decoder.sv
// ----------------------------------------------------------------------------
// ddr_cmd_decoder
//   Memory-side receiver for the DDR4 command/address bus. On every rising edge
//   of clock_t the command pins are decoded into a registered command record.
//   Per-bank timing state (tRCD / tRP / tRAS) is tracked so that protocol
//   violations can be flagged as one-cycle pulses with a saturating count.
//
// Ports
//   clock_t, reset_n        : memory clock, asynchronous active-low reset
//   cke                     : clock enable; 0 ignores the pins (timers still run)
//   cs_n, act_n, ras_n_a16,
//   cas_n_a15, we_n_a14     : command pins (ras/cas/we double as row bits on ACT)
//   addr17 .. addr9_0       : address pins
//   bg_addr, ba_addr        : bank group / bank
//   cmd_*                   : registered command record, one cycle after sampling
//   bank_open               : per-bank, 1 while ACTIVATING or ACTIVE
//   err_valid/err_code      : one-cycle violation pulse and its cause
//   err_count               : saturating violation count
// ----------------------------------------------------------------------------

// Per-bank state machine with a state-entry cycle counter and an ACT-to-now
// (ras) counter. The "met" outputs describe what a command sampled on the
// coming edge is allowed to do, so a command arriving exactly on the edge where
// a timer expires is treated as legal.
module ddr_bank_fsm #(
    parameter int T_RCD = 11,
    parameter int T_RP  = 11,
    parameter int T_RAS = 28
) (
    input  logic clock_t,
    input  logic reset_n,
    input  logic act_go,     // accepted ACT to this bank
    input  logic pre_go,     // accepted precharge (PRE, PREA, RD/WR+AP)
    output logic is_open,    // ACTIVATING or ACTIVE
    output logic eff_idle,   // ACT allowed on this edge
    output logic rcd_met,    // RD/WR allowed on this edge
    output logic ras_met     // PRE allowed on this edge (when open)
);
    typedef enum logic [1:0] {
        B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING
    } bank_state_e;

    // Counter value seen on the edge that is N cycles after the entry edge.
    localparam logic [7:0] RCD_LAST = 8'(T_RCD - 1);
    localparam logic [7:0] RP_LAST  = 8'(T_RP - 1);
    localparam logic [7:0] RAS_LAST = 8'(T_RAS - 1);

    bank_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ras_q, ras_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        ras_d   = (ras_q == 8'hFF) ? ras_q : ras_q + 8'd1;
        if (act_go) ras_d = 8'd0;
        case (state_q)
            B_IDLE: begin
                if (act_go) begin
                    state_d = B_ACTIVATING;
                    cnt_d   = 8'd0;
                end
            end
            B_ACTIVATING: begin
                if (pre_go) begin
                    state_d = B_PRECHARGING;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= RCD_LAST) begin
                    state_d = B_ACTIVE;
                    cnt_d   = 8'd0;
                end
            end
            B_ACTIVE: begin
                if (pre_go) begin
                    state_d = B_PRECHARGING;
                    cnt_d   = 8'd0;
                end
            end
            B_PRECHARGING: begin
                // ACT on the tRP expiry edge goes straight to ACTIVATING.
                if (act_go) begin
                    state_d = B_ACTIVATING;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= RP_LAST) begin
                    state_d = B_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = B_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= B_IDLE;
            cnt_q   <= 8'd0;
            ras_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ras_q   <= ras_d;
        end
    end

    assign is_open  = (state_q == B_ACTIVATING) || (state_q == B_ACTIVE);
    assign eff_idle = (state_q == B_IDLE) ||
                      ((state_q == B_PRECHARGING) && (cnt_q >= RP_LAST));
    assign rcd_met  = (state_q == B_ACTIVE) ||
                      ((state_q == B_ACTIVATING) && (cnt_q >= RCD_LAST));
    assign ras_met  = (ras_q >= RAS_LAST);
endmodule

module ddr_cmd_decoder #(
    parameter int BG_WIDTH = 2,
    parameter int BA_WIDTH = 2,
    parameter int T_RCD    = 11,
    parameter int T_RP     = 11,
    parameter int T_RAS    = 28,
    localparam int BANK_W    = BG_WIDTH + BA_WIDTH,
    localparam int NUM_BANKS = 2 ** BANK_W
) (
    input  logic                 clock_t,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n_a16,
    input  logic                 cas_n_a15,
    input  logic                 we_n_a14,
    input  logic                 addr17,
    input  logic                 addr13,
    input  logic                 bc_n_a12,
    input  logic                 addr11,
    input  logic                 ap_a10,
    input  logic [9:0]           addr9_0,
    input  logic [BG_WIDTH-1:0]  bg_addr,
    input  logic [BA_WIDTH-1:0]  ba_addr,
    output logic                 cmd_valid,
    output logic [3:0]           cmd_code,
    output logic [BANK_W-1:0]    cmd_bank,
    output logic [17:0]          cmd_row,
    output logic [9:0]           cmd_col,
    output logic                 cmd_ap,
    output logic                 cmd_bc_n,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [7:0]           err_count
);
    typedef enum logic [3:0] {
        CMD_DES  = 4'd0, CMD_NOP = 4'd1, CMD_ACT = 4'd2, CMD_RD  = 4'd3,
        CMD_WR   = 4'd4, CMD_PRE = 4'd5, CMD_PREA = 4'd6, CMD_REF = 4'd7,
        CMD_MRS  = 4'd8, CMD_ZQC = 4'd9, CMD_RFU = 4'd15
    } cmd_e;

    localparam logic [2:0] ERR_ACT_NOT_IDLE  = 3'd1;
    localparam logic [2:0] ERR_RDWR_NOT_OPEN = 3'd2;
    localparam logic [2:0] ERR_RDWR_TRCD     = 3'd3;
    localparam logic [2:0] ERR_ACT_TRP       = 3'd4;
    localparam logic [2:0] ERR_PRE_TRAS      = 3'd5;
    localparam logic [2:0] ERR_REF_NOT_IDLE  = 3'd6;
    localparam logic [2:0] ERR_RFU_CMD       = 3'd7;

    cmd_e                 dec;
    logic [BANK_W-1:0]    sel;
    logic [NUM_BANKS-1:0] sel_oh;
    logic [NUM_BANKS-1:0] b_open, b_idle, b_rcd, b_ras;
    logic [NUM_BANKS-1:0] act_go, pre_go;
    logic                 err_det;
    logic [2:0]           err_cd;

    logic                 cmd_valid_q, cmd_valid_d;
    logic [3:0]           cmd_code_q, cmd_code_d;
    logic [BANK_W-1:0]    cmd_bank_q, cmd_bank_d;
    logic [17:0]          cmd_row_q, cmd_row_d;
    logic [9:0]           cmd_col_q, cmd_col_d;
    logic                 cmd_ap_q, cmd_ap_d;
    logic                 cmd_bc_n_q, cmd_bc_n_d;
    logic                 err_valid_q, err_valid_d;
    logic [2:0]           err_code_q, err_code_d;
    logic [7:0]           err_count_q, err_count_d;

    assign sel    = {bg_addr, ba_addr};
    assign sel_oh = {{(NUM_BANKS-1){1'b0}}, 1'b1} << sel;

    // Command truth table; ras/cas/we are raw (active-low) pin levels.
    always_comb begin
        dec = CMD_DES;
        if (!cke || cs_n) begin
            dec = CMD_DES;
        end else if (!act_n) begin
            dec = CMD_ACT;
        end else begin
            case ({ras_n_a16, cas_n_a15, we_n_a14})
                3'b000: dec = CMD_MRS;
                3'b001: dec = CMD_REF;
                3'b010: dec = ap_a10 ? CMD_PREA : CMD_PRE;
                3'b011: dec = CMD_RFU;
                3'b100: dec = CMD_WR;
                3'b101: dec = CMD_RD;
                3'b110: dec = CMD_ZQC;
                3'b111: dec = CMD_NOP;
            endcase
        end
    end

    // Exactly one command per cycle, so at most one check can fire.
    always_comb begin
        err_det = 1'b0;
        err_cd  = 3'd0;
        case (dec)
            CMD_ACT: if (!b_idle[sel]) begin
                err_det = 1'b1;
                err_cd  = b_open[sel] ? ERR_ACT_NOT_IDLE : ERR_ACT_TRP;
            end
            CMD_RD, CMD_WR: if (!b_rcd[sel]) begin
                err_det = 1'b1;
                err_cd  = b_open[sel] ? ERR_RDWR_TRCD : ERR_RDWR_NOT_OPEN;
            end
            CMD_PRE: if (b_open[sel] && !b_ras[sel]) begin
                err_det = 1'b1;
                err_cd  = ERR_PRE_TRAS;
            end
            CMD_PREA: if (|(b_open & ~b_ras)) begin
                err_det = 1'b1;
                err_cd  = ERR_PRE_TRAS;
            end
            CMD_REF: if (!(&b_idle)) begin
                err_det = 1'b1;
                err_cd  = ERR_REF_NOT_IDLE;
            end
            CMD_RFU: begin
                err_det = 1'b1;
                err_cd  = ERR_RFU_CMD;
            end
            default: ;
        endcase
    end

    // Illegal commands leave bank state untouched.
    always_comb begin
        act_go = '0;
        pre_go = '0;
        if (!err_det) begin
            case (dec)
                CMD_ACT:        act_go = sel_oh;
                CMD_PRE:        pre_go = sel_oh & b_open;
                CMD_PREA:       pre_go = b_open;
                CMD_RD, CMD_WR: pre_go = ap_a10 ? sel_oh : '0;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        ddr_bank_fsm #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_bank (
            .clock_t  (clock_t),
            .reset_n  (reset_n),
            .act_go   (act_go[i]),
            .pre_go   (pre_go[i]),
            .is_open  (b_open[i]),
            .eff_idle (b_idle[i]),
            .rcd_met  (b_rcd[i]),
            .ras_met  (b_ras[i])
        );
    end

    always_comb begin
        cmd_valid_d = (dec != CMD_DES);
        cmd_code_d  = dec;
        cmd_bank_d  = cmd_bank_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        cmd_ap_d    = cmd_ap_q;
        cmd_bc_n_d  = cmd_bc_n_q;
        case (dec)
            CMD_ACT: begin
                cmd_bank_d = sel;
                cmd_row_d  = {addr17, ras_n_a16, cas_n_a15, we_n_a14, addr13,
                              bc_n_a12, addr11, ap_a10, addr9_0};
            end
            CMD_RD, CMD_WR: begin
                cmd_bank_d = sel;
                cmd_col_d  = addr9_0;
                cmd_ap_d   = ap_a10;
                cmd_bc_n_d = bc_n_a12;
            end
            CMD_PRE, CMD_PREA: cmd_bank_d = sel;
            default: ;
        endcase
        err_valid_d = err_det;
        err_code_d  = err_det ? err_cd : 3'd0;
        err_count_d = (err_det && err_count_q != 8'hFF) ? err_count_q + 8'd1
                                                        : err_count_q;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_DES;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cmd_ap_q    <= 1'b0;
            cmd_bc_n_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
            err_count_q <= 8'd0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            cmd_ap_q    <= cmd_ap_d;
            cmd_bc_n_q  <= cmd_bc_n_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign cmd_ap    = cmd_ap_q;
    assign cmd_bc_n  = cmd_bc_n_q;
    assign bank_open = b_open;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// ----------------------------------------------------------------------------
// tb_ddr_cmd_decoder
//   Directed bench for ddr_cmd_decoder: decode, tRCD / tRAS / tRP checks,
//   auto-precharge, refresh gating, pin sweep, error saturation, async reset.
// ----------------------------------------------------------------------------
module tb_ddr_cmd_decoder;
    logic        clock_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1, cs_n = 1'b1, act_n = 1'b1;
    logic        ras_n_a16 = 1'b1, cas_n_a15 = 1'b1, we_n_a14 = 1'b1;
    logic        addr17 = 1'b0, addr13 = 1'b0, bc_n_a12 = 1'b1, addr11 = 1'b0, ap_a10 = 1'b0;
    logic [9:0]  addr9_0 = '0;
    logic [1:0]  bg_addr = '0, ba_addr = '0;
    logic        cmd_valid, cmd_ap, cmd_bc_n, err_valid;
    logic [3:0]  cmd_code, cmd_bank;
    logic [17:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [15:0] bank_open;
    logic [2:0]  err_code;
    logic [7:0]  err_count;

    int tests_run = 0;
    int fails = 0;

    ddr_cmd_decoder dut (
        .clock_t(clock_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
        .addr17(addr17), .addr13(addr13), .bc_n_a12(bc_n_a12), .addr11(addr11),
        .ap_a10(ap_a10), .addr9_0(addr9_0), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap), .cmd_bc_n(cmd_bc_n),
        .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code),
        .err_count(err_count)
    );

    always #5 clock_t = ~clock_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Place a command on the pins; a[] is the 18-bit row/address image.
    task automatic drive(input logic an, input logic [2:0] rcw, input logic [3:0] bank,
                         input logic [17:0] a);
        cs_n  = 1'b0;
        act_n = an;
        {addr17, ras_n_a16, cas_n_a15, we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0} = a;
        if (an) {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
        {bg_addr, ba_addr} = bank;
    endtask

    // Drive for one edge, land 1 time unit after it, then deselect.
    task automatic issue(input logic an, input logic [2:0] rcw, input logic [3:0] bank,
                         input logic [17:0] a);
        drive(an, rcw, bank, a);
        @(posedge clock_t); #1;
        cs_n  = 1'b1;
        act_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock_t);
        #1;
    endtask

    task automatic do_act(input logic [3:0] bank, input logic [17:0] row);
        issue(1'b0, 3'b111, bank, row);
    endtask

    task automatic do_rd(input logic [3:0] bank, input logic [9:0] col, input logic ap);
        issue(1'b1, 3'b101, bank, {5'b0, 1'b1, 1'b0, ap, col});
    endtask

    task automatic do_pre(input logic [3:0] bank, input logic all);
        issue(1'b1, 3'b010, bank, {7'b0, all, 10'b0});
    endtask

    task automatic do_op(input logic [2:0] rcw);
        issue(1'b1, rcw, 4'd0, 18'b0);
    endtask

    task automatic do_reset();
        cs_n = 1'b1; act_n = 1'b1; cke = 1'b1;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", cmd_valid); end
        tests_run++; if (cmd_code !== 4'd0) begin fails++; $display("FAIL rst_code: got %0d want 0", cmd_code); end
        tests_run++; if (bank_open !== 16'h0) begin fails++; $display("FAIL rst_bank_open: got %h want 0000", bank_open); end
        tests_run++; if (err_valid !== 1'b0 || err_code !== 3'd0) begin fails++; $display("FAIL rst_err: got %0b/%0d want 0/0", err_valid, err_code); end
        tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        tests_run++; if (cmd_row !== 18'h0 || cmd_col !== 10'h0 || cmd_bank !== 4'h0) begin fails++; $display("FAIL rst_record: got row %h col %h bank %h want 0", cmd_row, cmd_col, cmd_bank); end
        @(posedge clock_t); #1;
        reset_n = 1'b1;
        idle(1);
        tests_run++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd0) begin fails++; $display("FAIL post_rst_des: got %0b/%0d want 0/0", cmd_valid, cmd_code); end
    endtask

    task automatic test_act_rd();
        do_reset();
        do_act(4'd9, 18'h0ABCD);
        tests_run++; if (cmd_valid !== 1'b1 || cmd_code !== 4'd2) begin fails++; $display("FAIL act_code: got %0b/%0d want 1/2", cmd_valid, cmd_code); end
        tests_run++; if (cmd_bank !== 4'd9) begin fails++; $display("FAIL act_bank: got %0d want 9", cmd_bank); end
        tests_run++; if (cmd_row !== 18'h0ABCD) begin fails++; $display("FAIL act_row: got %h want 0abcd", cmd_row); end
        tests_run++; if (bank_open !== 16'h0200 || err_valid !== 1'b0) begin fails++; $display("FAIL act_open: got %h err %0b want 0200 err 0", bank_open, err_valid); end
        idle(10);
        do_rd(4'd9, 10'h155, 1'b0);
        tests_run++; if (cmd_code !== 4'd3 || cmd_col !== 10'h155) begin fails++; $display("FAIL rd_code_col: got %0d/%h want 3/155", cmd_code, cmd_col); end
        tests_run++; if (cmd_ap !== 1'b0 || cmd_bc_n !== 1'b1) begin fails++; $display("FAIL rd_ap_bc: got %0b/%0b want 0/1", cmd_ap, cmd_bc_n); end
        tests_run++; if (err_valid !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL rd_no_err: got %0b cnt %0d want 0 cnt 0", err_valid, err_count); end
        tests_run++; if (bank_open[9] !== 1'b1) begin fails++; $display("FAIL rd_open9: got %0b want 1", bank_open[9]); end
        tests_run++; if (cmd_row !== 18'h0ABCD) begin fails++; $display("FAIL rd_row_hold: got %h want 0abcd", cmd_row); end
        idle(1);
        tests_run++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd0 || cmd_col !== 10'h155) begin fails++; $display("FAIL des_hold: got %0b/%0d col %h want 0/0 col 155", cmd_valid, cmd_code, cmd_col); end
    endtask

    task automatic test_trcd();
        do_reset();
        do_act(4'd0, 18'h00001);
        idle(4);
        do_rd(4'd0, 10'h001, 1'b0);
        tests_run++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin fails++; $display("FAIL trcd_err: got %0b/%0d want 1/3", err_valid, err_code); end
        tests_run++; if (err_count !== 8'd1 || cmd_code !== 4'd3) begin fails++; $display("FAIL trcd_cnt: got cnt %0d code %0d want 1/3", err_count, cmd_code); end
        tests_run++; if (bank_open[0] !== 1'b1) begin fails++; $display("FAIL trcd_open: got %0b want 1", bank_open[0]); end
        idle(5);
        tests_run++; if (err_valid !== 1'b0) begin fails++; $display("FAIL trcd_pulse: got %0b want 0", err_valid); end
        do_rd(4'd0, 10'h002, 1'b0);
        tests_run++; if (err_valid !== 1'b0 || err_count !== 8'd1) begin fails++; $display("FAIL trcd_ok: got %0b cnt %0d want 0 cnt 1", err_valid, err_count); end
    endtask

    task automatic test_tras_trp();
        do_reset();
        do_act(4'd3, 18'h00003);
        idle(19);
        do_pre(4'd3, 1'b0);
        tests_run++; if (err_valid !== 1'b1 || err_code !== 3'd5 || cmd_code !== 4'd5) begin fails++; $display("FAIL tras_err: got %0b/%0d code %0d want 1/5 code 5", err_valid, err_code, cmd_code); end
        tests_run++; if (bank_open[3] !== 1'b1) begin fails++; $display("FAIL tras_still_open: got %0b want 1", bank_open[3]); end
        idle(7);
        do_pre(4'd3, 1'b0);
        tests_run++; if (err_valid !== 1'b0 || bank_open[3] !== 1'b0) begin fails++; $display("FAIL tras_ok: got err %0b open %0b want 0/0", err_valid, bank_open[3]); end
        idle(4);
        do_act(4'd3, 18'h00003);
        tests_run++; if (err_valid !== 1'b1 || err_code !== 3'd4 || cmd_code !== 4'd2) begin fails++; $display("FAIL trp_err: got %0b/%0d code %0d want 1/4 code 2", err_valid, err_code, cmd_code); end
        tests_run++; if (bank_open[3] !== 1'b0) begin fails++; $display("FAIL trp_closed: got %0b want 0", bank_open[3]); end
        idle(5);
        do_act(4'd3, 18'h00003);
        tests_run++; if (err_valid !== 1'b0 || bank_open[3] !== 1'b1) begin fails++; $display("FAIL trp_ok: got err %0b open %0b want 0/1", err_valid, bank_open[3]); end
        tests_run++; if (err_count !== 8'd2) begin fails++; $display("FAIL tras_trp_cnt: got %0d want 2", err_count); end
        do_act(4'd3, 18'h00003);
        tests_run++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin fails++; $display("FAIL act_not_idle: got %0b/%0d want 1/1", err_valid, err_code); end
    endtask

    task automatic test_ap_ref();
        do_reset();
        do_act(4'd5, 18'h00005);
        idle(10);
        do_rd(4'd5, 10'h3FF, 1'b1);
        tests_run++; if (err_valid !== 1'b0 || cmd_ap !== 1'b1 || bank_open[5] !== 1'b0) begin fails++; $display("FAIL rd_ap: got err %0b ap %0b open %0b want 0/1/0", err_valid, cmd_ap, bank_open[5]); end
        idle(2);
        do_op(3'b001);
        tests_run++; if (cmd_code !== 4'd7 || err_valid !== 1'b1 || err_code !== 3'd6) begin fails++; $display("FAIL ref_busy: got code %0d err %0b/%0d want 7 1/6", cmd_code, err_valid, err_code); end
        idle(7);
        do_op(3'b001);
        tests_run++; if (cmd_code !== 4'd7 || err_valid !== 1'b0) begin fails++; $display("FAIL ref_ok: got code %0d err %0b want 7 0", cmd_code, err_valid); end
    endtask

    task automatic test_pin_sweep();
        do_reset();
        drive(1'b0, 3'b111, 4'd2, 18'h00002);
        cs_n = 1'b1;
        idle(1);
        tests_run++; if (cmd_code !== 4'd0 || cmd_valid !== 1'b0 || bank_open !== 16'h0) begin fails++; $display("FAIL cs_des: got %0d/%0b open %h want 0/0 0000", cmd_code, cmd_valid, bank_open); end
        act_n = 1'b1;
        do_op(3'b011);
        tests_run++; if (cmd_code !== 4'd15 || cmd_valid !== 1'b1 || err_code !== 3'd7 || err_valid !== 1'b1) begin fails++; $display("FAIL rfu: got %0d/%0b err %0b/%0d want 15/1 1/7", cmd_code, cmd_valid, err_valid, err_code); end
        do_op(3'b000);
        tests_run++; if (cmd_code !== 4'd8 || err_valid !== 1'b0) begin fails++; $display("FAIL mrs: got %0d err %0b want 8 0", cmd_code, err_valid); end
        do_op(3'b110);
        tests_run++; if (cmd_code !== 4'd9) begin fails++; $display("FAIL zqc: got %0d want 9", cmd_code); end
        do_op(3'b111);
        tests_run++; if (cmd_code !== 4'd1 || cmd_valid !== 1'b1) begin fails++; $display("FAIL nop: got %0d/%0b want 1/1", cmd_code, cmd_valid); end
        issue(1'b1, 3'b100, 4'd7, 18'h00000);
        tests_run++; if (cmd_code !== 4'd4 || err_code !== 3'd2 || err_count !== 8'd2) begin fails++; $display("FAIL wr_idle: got %0d err %0d cnt %0d want 4 2 2", cmd_code, err_code, err_count); end
        cke = 1'b0;
        do_act(4'd2, 18'h00002);
        cke = 1'b1;
        tests_run++; if (cmd_code !== 4'd0 || bank_open !== 16'h0) begin fails++; $display("FAIL cke_des: got %0d open %h want 0 0000", cmd_code, bank_open); end
        do_act(4'd1, 18'h00001);
        do_act(4'd6, 18'h00006);
        idle(8);
        do_pre(4'd0, 1'b1);
        tests_run++; if (cmd_code !== 4'd6 || err_code !== 3'd5 || bank_open !== 16'h0042) begin fails++; $display("FAIL prea_tras: got %0d err %0d open %h want 6 5 0042", cmd_code, err_code, bank_open); end
        idle(18);
        do_pre(4'd0, 1'b1);
        tests_run++; if (cmd_code !== 4'd6 || err_valid !== 1'b0 || bank_open !== 16'h0) begin fails++; $display("FAIL prea_ok: got %0d err %0b open %h want 6 0 0000", cmd_code, err_valid, bank_open); end
        tests_run++; if (err_count !== 8'd3) begin fails++; $display("FAIL sweep_cnt: got %0d want 3", err_count); end
    endtask

    task automatic test_sat_reset();
        do_reset();
        drive(1'b1, 3'b011, 4'd0, 18'h0);
        repeat (254) @(posedge clock_t);
        #1;
        tests_run++; if (err_count !== 8'd254) begin fails++; $display("FAIL sat_254: got %0d want 254", err_count); end
        repeat (46) @(posedge clock_t);
        #1;
        cs_n = 1'b1;
        tests_run++; if (err_count !== 8'd255 || err_valid !== 1'b1 || err_code !== 3'd7) begin fails++; $display("FAIL sat_255: got %0d err %0b/%0d want 255 1/7", err_count, err_valid, err_code); end
        do_act(4'd2, 18'h12345);
        idle(3);
        tests_run++; if (bank_open[2] !== 1'b1) begin fails++; $display("FAIL pre_rst_open: got %0b want 1", bank_open[2]); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (bank_open !== 16'h0 || err_count !== 8'd0 || err_valid !== 1'b0) begin fails++; $display("FAIL async_rst: got open %h cnt %0d err %0b want 0000 0 0", bank_open, err_count, err_valid); end
        tests_run++; if (cmd_row !== 18'h0 || cmd_code !== 4'd0 || cmd_valid !== 1'b0 || cmd_bank !== 4'd0) begin fails++; $display("FAIL async_rst_rec: got row %h code %0d v %0b bank %0d want 0", cmd_row, cmd_code, cmd_valid, cmd_bank); end
        reset_n = 1'b1;
        idle(1);
        tests_run++; if (bank_open !== 16'h0) begin fails++; $display("FAIL post_async_rst: got %h want 0000", bank_open); end
    endtask

    initial begin
        test_reset();
        test_act_rd();
        test_trcd();
        test_tras_trp();
        test_ap_ref();
        test_pin_sweep();
        test_sat_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
